fpu_f2i_converter: RTL
======================

# fpu_f2i_converter

Iterative IEEE-754 single-precision to signed 32-bit integer converter. It is the decode-side companion to the combinational FP add/sub datapath: it unpacks a float32, classifies it, aligns the significand with a one-bit-per-cycle shifter and emits a two's-complement int32. Rounding is truncation toward zero, matching the adder's truncating datapath. It sits between the FPU result bus and integer consumers behind a valid/ready handshake.

## Interface
- No parameters. Widths are fixed by the float32/int32 formats.
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  in_data holds an operand
- in_ready  out  1  converter can accept; high only in IDLE
- in_data  in  32  float32 operand {sign, exp[7:0], frac[22:0]}
- out_valid  out  1  result fields valid; held until accepted
- out_ready  in  1  consumer accepts the result
- out_data  out  32  signed int32 result
- invalid  out  1  operand was NaN or ±Inf
- overflow  out  1  finite operand outside int32 range
- inexact  out  1  nonzero fraction bits were discarded

## Operation
- States are IDLE, SHIFT and DONE.
- Accept occurs when in_valid && in_ready at a clock edge. At that edge the operand is classified and captured, using e = exp − 127.
  - exp == 255 gives invalid=1 and out_data = sign ? 0x80000000 : 0x7FFFFFFF. Next state is DONE.
  - exp == 0 (zero or denormal) gives out_data = 0, inexact = (frac != 0). Next state is DONE.
  - e < 0 gives out_data = 0, inexact = 1. Next state is DONE.
  - e ≥ 31 gives overflow=1 and saturation as for Inf. The exception is operand 0xCF000000 (−2^31), which gives 0x80000000 with no flag. Next state is DONE.
  - Otherwise: acc = {8'b0, 1, frac}, dir = (e ≥ 23 ? left : right), cnt = |e − 23| (0..23), sticky = 0. Next state is SHIFT.
- SHIFT, cnt != 0: acc shifts one bit in dir and cnt decrements. On a right shift, sticky |= acc[0] before the shift.
- SHIFT, cnt == 0: out_data = sign ? −acc : acc, inexact = sticky. Next state is DONE.
- DONE: out_valid=1. All outputs are stable while out_ready=0. When out_valid && out_ready, the block returns to IDLE and out_valid clears.
- Exactly one operand is in flight. There is no overlap of accept and output.
- Flags are mutually exclusive per result. invalid and overflow always coincide with saturated out_data.

## Timing
- Reset values: state=IDLE, in_ready=1, out_valid=0, out_data=0, invalid=overflow=inexact=0.
- Special/zero/small operands: out_valid is high in the cycle after the accept edge (latency 1).
- Normal operands: out_valid rises after accept edge + (cnt+1) edges.
  - The range is 1 cycle (e=23) to 24 cycles (e=0).
- in_ready is low from the accept edge until the edge after the out handshake.
  - The next accept is possible at the earliest 1 cycle after the out handshake.
- Reset asserted mid-SHIFT or in DONE aborts immediately to reset values. The pending result is discarded.
- in_data is sampled only at the accept edge. Later changes are ignored.

## Structure
- Package fpu_pkg holds:
  - the constants FP32_EXP_W=8, FP32_FRAC_W=23, FP32_BIAS=127, INT32_MAX=32'h7FFFFFFF, INT32_MIN=32'h80000000;
  - the state enum typedef f2i_state_t {IDLE, SHIFT, DONE};
  - a packed struct fp32_t {sign, exp, frac}, shared with the add/sub unit.
- One sub-module, fpu_f2i_classify, is purely combinational. It takes the fp32_t and produces the class, the special result/flags, dir and cnt.
- The top module holds the FSM, acc/cnt/sticky registers and output registers.

## Test plan
- 0x3F800000 (1.0): out_data=1, no flags, out_valid 24 cycles after accept. 0x4E800000 (2^30): 0x40000000, 8 cycles.
- 0xC0200000 (−2.5): 0xFFFFFFFE, inexact=1. 0x3F000000 (0.5): 0, inexact=1, latency 1.
- 0x4F000000 gives 0x7FFFFFFF with overflow=1. 0xCF000000 gives 0x80000000 with no flags. 0xFF800000 (−Inf) gives 0x80000000 with invalid=1. 0x7FC00000 gives 0x7FFFFFFF with invalid=1.
- 0x00000001 (denormal) gives 0, inexact=1. 0x80000000 (−0) gives 0 with no flags.
- Backpressure: hold out_ready=0 for 5 cycles after 0x42F60000 (123.0).
  - out_data=123 stays stable and in_ready stays 0.
  - The next operand is accepted 1 cycle after the handshake.
- Assert rst_n low mid-SHIFT:
  - All outputs return to reset values asynchronously.
  - After release, 0x41200000 converts to 10 correctly.

Source files
------------

// File: rtl/fpu_pkg.sv
// fpu_pkg
// Shared definitions for the FPU slice: float32 field widths and bias, int32
// saturation limits, the float-to-int converter state and class encodings,
// and the packed float32 view that is also used by the add/sub unit.
package fpu_pkg;

    localparam int FP32_EXP_W  = 8;
    localparam int FP32_FRAC_W = 23;
    localparam int FP32_BIAS   = 127;

    localparam logic [31:0] INT32_MAX = 32'h7FFF_FFFF;
    localparam logic [31:0] INT32_MIN = 32'h8000_0000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } f2i_state_t;

    // DIRECT: the result is known at accept time. ALIGN: the significand
    // must be walked through the one-bit-per-cycle shifter.
    typedef enum logic {
        CLS_DIRECT = 1'b0,
        CLS_ALIGN  = 1'b1
    } f2i_class_t;

    typedef enum logic {
        DIR_RIGHT = 1'b0,
        DIR_LEFT  = 1'b1
    } f2i_dir_t;

    typedef struct packed {
        logic                   sign;
        logic [FP32_EXP_W-1:0]  exp;
        logic [FP32_FRAC_W-1:0] frac;
    } fp32_t;

endpackage

// File: rtl/fpu_f2i_classify.sv
// fpu_f2i_classify
// Combinational operand classifier for the float32 -> int32 converter.
// Ports:
//   i_op        float32 operand
//   o_class     CLS_DIRECT (result below is final) or CLS_ALIGN (needs shifting)
//   o_result    final int32 result for CLS_DIRECT operands
//   o_invalid   NaN / Inf operand
//   o_overflow  finite operand outside int32 range
//   o_inexact   nonzero fraction discarded (zero/denormal/|x|<1 cases)
//   o_dir       alignment direction for CLS_ALIGN
//   o_cnt       alignment shift count |e - 23| for CLS_ALIGN (0..23)
module fpu_f2i_classify
    import fpu_pkg::*;
(
    input  fp32_t       i_op,
    output f2i_class_t  o_class,
    output logic [31:0] o_result,
    output logic        o_invalid,
    output logic        o_overflow,
    output logic        o_inexact,
    output f2i_dir_t    o_dir,
    output logic [4:0]  o_cnt
);

    localparam logic [7:0] EXP_MAX    = 8'hFF;
    localparam logic [7:0] EXP_ONE    = 8'(FP32_BIAS);                // e = 0
    localparam logic [7:0] EXP_POINT  = 8'(FP32_BIAS + FP32_FRAC_W);  // e = 23
    localparam logic [7:0] EXP_OVF    = 8'(FP32_BIAS + 31);           // e = 31
    // Low five bits of EXP_POINT; the shift counts are computed modulo 32
    // from exp[4:0], which is exact because both counts lie in 0..23.
    localparam logic [4:0] POINT_LSB5 = EXP_POINT[4:0];

    always_comb begin
        o_class    = CLS_DIRECT;
        o_result   = '0;
        o_invalid  = 1'b0;
        o_overflow = 1'b0;
        o_inexact  = 1'b0;
        o_dir      = DIR_RIGHT;
        o_cnt      = '0;

        if (i_op.exp == EXP_MAX) begin
            o_invalid = 1'b1;
            o_result  = i_op.sign ? INT32_MIN : INT32_MAX;
        end else if (i_op.exp == '0) begin
            o_inexact = |i_op.frac;
        end else if (i_op.exp < EXP_ONE) begin
            o_inexact = 1'b1;
        end else if (i_op.exp >= EXP_OVF) begin
            // -2^31 is the single e = 31 value that is representable.
            if (i_op.sign && i_op.exp == EXP_OVF && i_op.frac == '0) begin
                o_result = INT32_MIN;
            end else begin
                o_overflow = 1'b1;
                o_result   = i_op.sign ? INT32_MIN : INT32_MAX;
            end
        end else begin
            o_class = CLS_ALIGN;
            if (i_op.exp >= EXP_POINT) begin
                o_dir = DIR_LEFT;
                o_cnt = i_op.exp[4:0] - POINT_LSB5;
            end else begin
                o_dir = DIR_RIGHT;
                o_cnt = POINT_LSB5 - i_op.exp[4:0];
            end
        end
    end

endmodule

// File: rtl/fpu_f2i_converter.sv
// fpu_f2i_converter
// Iterative float32 -> signed int32 converter, truncating toward zero.
// Special, zero and |x|<1 operands resolve at the accept edge; normal
// operands are aligned one bit per cycle in SHIFT.
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   in_valid/in_ready       operand handshake (ready only in IDLE)
//   in_data                 float32 operand, sampled only at accept
//   out_valid/out_ready     result handshake, result held until accepted
//   out_data                int32 result
//   invalid/overflow/inexact  result flags (mutually exclusive)
module fpu_f2i_converter
    import fpu_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic        invalid,
    output logic        overflow,
    output logic        inexact
);

    f2i_state_t  r_state;
    f2i_state_t  w_state_next;

    logic [31:0] r_acc;
    logic [4:0]  r_cnt;
    f2i_dir_t    r_dir;
    logic        r_sticky;
    logic        r_sign;

    logic [31:0] r_out_data;
    logic        r_invalid;
    logic        r_overflow;
    logic        r_inexact;

    fp32_t       w_op;
    f2i_class_t  w_class;
    logic [31:0] w_result;
    logic        w_invalid;
    logic        w_overflow;
    logic        w_inexact;
    f2i_dir_t    w_dir;
    logic [4:0]  w_cnt;
    logic        w_accept;

    assign w_op = in_data;

    fpu_f2i_classify u_classify (
        .i_op       (w_op),
        .o_class    (w_class),
        .o_result   (w_result),
        .o_invalid  (w_invalid),
        .o_overflow (w_overflow),
        .o_inexact  (w_inexact),
        .o_dir      (w_dir),
        .o_cnt      (w_cnt)
    );

    always_comb begin
        w_state_next = r_state;
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        w_accept     = 1'b0;
        case (r_state)
            IDLE: begin
                in_ready = 1'b1;
                w_accept = in_valid;
                if (in_valid) begin
                    w_state_next = (w_class == CLS_ALIGN) ? SHIFT : DONE;
                end
            end
            SHIFT: begin
                if (r_cnt == '0) begin
                    w_state_next = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc      <= '0;
            r_cnt      <= '0;
            r_dir      <= DIR_RIGHT;
            r_sticky   <= 1'b0;
            r_sign     <= 1'b0;
            r_out_data <= '0;
            r_invalid  <= 1'b0;
            r_overflow <= 1'b0;
            r_inexact  <= 1'b0;
        end else if (w_accept) begin
            r_sign   <= w_op.sign;
            r_acc    <= {8'b0, 1'b1, w_op.frac};
            r_cnt    <= w_cnt;
            r_dir    <= w_dir;
            r_sticky <= 1'b0;
            // Direct classes publish their result now; aligned ones clear
            // the outputs and fill them in when the shifter finishes.
            r_out_data <= w_result;
            r_invalid  <= w_invalid;
            r_overflow <= w_overflow;
            r_inexact  <= w_inexact;
        end else if (r_state == SHIFT) begin
            if (r_cnt != '0) begin
                r_cnt <= r_cnt - 5'd1;
                if (r_dir == DIR_LEFT) begin
                    r_acc <= {r_acc[30:0], 1'b0};
                end else begin
                    r_sticky <= r_sticky | r_acc[0];
                    r_acc    <= {1'b0, r_acc[31:1]};
                end
            end else begin
                r_out_data <= r_sign ? (~r_acc + 32'd1) : r_acc;
                r_inexact  <= r_sticky;
            end
        end
    end

    assign out_data = r_out_data;
    assign invalid  = r_invalid;
    assign overflow = r_overflow;
    assign inexact  = r_inexact;

endmodule
